// File: rtl/dodge_game_core.sv
// Game-state engine for the LED-matrix dodge game.
// Tracks position, lives, invulnerability and BCD survival score per player lane,
// under a global IDLE/RUN/OVER game FSM.
//
//   state | meaning
//   IDLE  | players parked at lane bit 0, full lives, scores cleared; waits for start
//   RUN   | movement, collision on tick and scoring active
//   OVER  | everything frozen until start returns to IDLE
//
//   sub   | meaning
//   NORMAL| player can be hit
//   INV   | post-hit invulnerability, counts down on ticks
//   DEAD  | no lives left, position blanked
module dodge_game_core #(
    parameter int PLAYERS      = 2,
    parameter int LANE_W       = 4,
    parameter int LIVES        = 3,
    parameter int INV_TICKS    = 2,
    parameter int SCORE_DIGITS = 2,
    parameter int WRAP         = 0
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic                             i_start,
    input  logic                             i_tick,
    input  logic [PLAYERS-1:0]               i_move_left,
    input  logic [PLAYERS-1:0]               i_move_right,
    input  logic [PLAYERS*LANE_W-1:0]        i_map_row,
    output logic [PLAYERS*LANE_W-1:0]        o_pos,
    output logic [PLAYERS-1:0]               o_alive,
    output logic [PLAYERS-1:0]               o_hit_flash,
    output logic [PLAYERS*3-1:0]             o_lives,
    output logic [PLAYERS*SCORE_DIGITS*4-1:0] o_score,
    output logic [1:0]                       o_state,
    output logic                             o_game_over
);

    localparam int SW = SCORE_DIGITS * 4;
    localparam logic [SW-1:0] SCORE_MAX = {SCORE_DIGITS{4'h9}};

    typedef enum logic [1:0] {ST_IDLE = 2'b00, ST_RUN = 2'b01, ST_OVER = 2'b10} game_st_t;
    typedef enum logic [1:0] {SUB_NORMAL = 2'b00, SUB_INV = 2'b01, SUB_DEAD = 2'b10} sub_st_t;

    game_st_t          r_state, w_state;
    logic [LANE_W-1:0] r_pos   [PLAYERS];
    logic [LANE_W-1:0] w_pos   [PLAYERS];
    logic [2:0]        r_lives [PLAYERS];
    logic [2:0]        w_lives [PLAYERS];
    sub_st_t           r_sub   [PLAYERS];
    sub_st_t           w_sub   [PLAYERS];
    logic [2:0]        r_inv   [PLAYERS];
    logic [2:0]        w_inv   [PLAYERS];
    logic [SW-1:0]     r_score [PLAYERS];
    logic [SW-1:0]     w_score [PLAYERS];
    logic              w_any_alive;
    logic              w_load_init;

    // Left moves toward the higher lane index.
    function automatic logic [LANE_W-1:0] f_left(input logic [LANE_W-1:0] v);
        if (WRAP != 0)         return {v[LANE_W-2:0], v[LANE_W-1]};
        else if (v[LANE_W-1]) return v;
        else                   return v << 1;
    endfunction

    // Right moves toward the lower lane index.
    function automatic logic [LANE_W-1:0] f_right(input logic [LANE_W-1:0] v);
        if (WRAP != 0) return {v[0], v[LANE_W-1:1]};
        else if (v[0]) return v;
        else           return v >> 1;
    endfunction

    // Saturating BCD increment, ripple carry from the lowest digit.
    function automatic logic [SW-1:0] f_bcd_inc(input logic [SW-1:0] v);
        logic [SW-1:0] r;
        logic          c;
        r = v;
        c = 1'b1;
        if (v != SCORE_MAX) begin
            for (int d = 0; d < SCORE_DIGITS; d++) begin
                if (c) begin
                    if (r[d*4 +: 4] == 4'd9) begin
                        r[d*4 +: 4] = 4'd0;
                    end else begin
                        r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
                        c = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    // Next game state and per-player next state.
    always_comb begin
        w_state     = r_state;
        w_pos       = r_pos;
        w_lives     = r_lives;
        w_sub       = r_sub;
        w_inv       = r_inv;
        w_score     = r_score;
        w_any_alive = 1'b0;
        w_load_init = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load_init = 1'b1;
                if (i_start) w_state = ST_RUN;
            end
            ST_RUN: begin
                for (int p = 0; p < PLAYERS; p++) begin
                    if (r_sub[p] != SUB_DEAD) begin
                        if (i_move_left[p] && !i_move_right[p])
                            w_pos[p] = f_left(r_pos[p]);
                        else if (i_move_right[p] && !i_move_left[p])
                            w_pos[p] = f_right(r_pos[p]);
                        if (i_tick) begin
                            // Collision looks at the registered position, not the moved one.
                            if (r_sub[p] == SUB_NORMAL &&
                                (r_pos[p] & i_map_row[p*LANE_W +: LANE_W]) != '0) begin
                                w_lives[p] = r_lives[p] - 3'd1;
                                if (r_lives[p] <= 3'd1) begin
                                    w_lives[p] = 3'd0;
                                    w_sub[p]   = SUB_DEAD;
                                    w_pos[p]   = '0;
                                    w_inv[p]   = 3'd0;
                                end else if (INV_TICKS == 0) begin
                                    w_sub[p] = SUB_NORMAL;
                                end else begin
                                    w_sub[p] = SUB_INV;
                                    w_inv[p] = 3'(INV_TICKS);
                                end
                            end else if (r_sub[p] == SUB_INV) begin
                                if (r_inv[p] <= 3'd1) begin
                                    w_sub[p] = SUB_NORMAL;
                                    w_inv[p] = 3'd0;
                                end else begin
                                    w_inv[p] = r_inv[p] - 3'd1;
                                end
                            end
                            if (w_sub[p] != SUB_DEAD) w_score[p] = f_bcd_inc(r_score[p]);
                        end
                    end
                    if (w_sub[p] != SUB_DEAD) w_any_alive = 1'b1;
                end
                if (!w_any_alive) w_state = ST_OVER;
            end
            ST_OVER: begin
                if (i_start) begin
                    w_state     = ST_IDLE;
                    w_load_init = 1'b1;
                end
            end
            default: w_state = ST_IDLE;
        endcase
        if (w_load_init) begin
            for (int p = 0; p < PLAYERS; p++) begin
                w_pos[p]   = LANE_W'(1);
                w_lives[p] = 3'(LIVES);
                w_sub[p]   = SUB_NORMAL;
                w_inv[p]   = 3'd0;
                w_score[p] = '0;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            for (int p = 0; p < PLAYERS; p++) begin
                r_pos[p]   <= LANE_W'(1);
                r_lives[p] <= 3'(LIVES);
                r_sub[p]   <= SUB_NORMAL;
                r_inv[p]   <= 3'd0;
                r_score[p] <= '0;
            end
        end else begin
            r_state <= w_state;
            r_pos   <= w_pos;
            r_lives <= w_lives;
            r_sub   <= w_sub;
            r_inv   <= w_inv;
            r_score <= w_score;
        end
    end

    // Pack per-player registers onto the output buses.
    always_comb begin
        o_pos       = '0;
        o_alive     = '0;
        o_hit_flash = '0;
        o_lives     = '0;
        o_score     = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            o_pos[p*LANE_W +: LANE_W] = r_pos[p];
            o_alive[p]                = (r_sub[p] != SUB_DEAD);
            o_hit_flash[p]            = (r_sub[p] == SUB_INV);
            o_lives[p*3 +: 3]         = r_lives[p];
            o_score[p*SW +: SW]       = r_score[p];
        end
        o_state     = r_state;
        o_game_over = (r_state == ST_OVER);
    end

endmodule

// File: tb/tb_dodge_game_core.sv
// Self-checking bench for dodge_game_core: vector table plus corner sequences,
// expected records queued at drive time and compared after the sampling edge.
module tb_dodge_game_core;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        tick = 1'b0;
    logic [1:0]  ml = '0;
    logic [1:0]  mr = '0;
    logic [7:0]  map = '0;

    logic [7:0]  pos, w_pos;
    logic [1:0]  alive, w_alive;
    logic [1:0]  hf, w_hf;
    logic [5:0]  lives, w_lives;
    logic [15:0] score, w_score;
    logic [1:0]  state, w_state;
    logic        go, w_go;

    dodge_game_core #(.WRAP(0)) u_dut (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_tick(tick),
        .i_move_left(ml), .i_move_right(mr), .i_map_row(map),
        .o_pos(pos), .o_alive(alive), .o_hit_flash(hf), .o_lives(lives),
        .o_score(score), .o_state(state), .o_game_over(go));

    dodge_game_core #(.WRAP(1)) u_dut_wrap (
        .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_tick(tick),
        .i_move_left(ml), .i_move_right(mr), .i_map_row(map),
        .o_pos(w_pos), .o_alive(w_alive), .o_hit_flash(w_hf), .o_lives(w_lives),
        .o_score(w_score), .o_state(w_state), .o_game_over(w_go));

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic        s;
        logic        t;
        logic [1:0]  l;
        logic [1:0]  r;
        logic [7:0]  m;
        logic [7:0]  pos;
        logic [5:0]  lives;
        logic [15:0] score;
        logic [1:0]  st;
        logic [1:0]  alive;
        logic [1:0]  hf;
        logic        cw;
        logic [7:0]  wpos;
    } vec_t;

    vec_t vecs[27];
    vec_t sb_q[$];

    function automatic vec_t mk(input logic s, input logic t, input logic [1:0] l,
                                input logic [1:0] r, input logic [7:0] m, input logic [7:0] p,
                                input logic [5:0] lv, input logic [15:0] sc, input logic [1:0] st,
                                input logic [1:0] al, input logic [1:0] h, input logic cw,
                                input logic [7:0] wp);
        vec_t v;
        v.s = s; v.t = t; v.l = l; v.r = r; v.m = m; v.pos = p; v.lives = lv;
        v.score = sc; v.st = st; v.alive = al; v.hf = h; v.cw = cw; v.wpos = wp;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic compare(input vec_t e, input string tag);
        chk({tag, ".pos"},       32'(pos),   32'(e.pos));
        chk({tag, ".lives"},     32'(lives), 32'(e.lives));
        chk({tag, ".score"},     32'(score), 32'(e.score));
        chk({tag, ".state"},     32'(state), 32'(e.st));
        chk({tag, ".alive"},     32'(alive), 32'(e.alive));
        chk({tag, ".hit_flash"}, 32'(hf),    32'(e.hf));
        chk({tag, ".game_over"}, 32'(go),    32'(e.st == 2'b10));
        if (e.cw) chk({tag, ".wrap_pos"}, 32'(w_pos), 32'(e.wpos));
    endtask

    task automatic step(input vec_t v, input logic chk_en, input string tag);
        vec_t e;
        @(negedge clk);
        start = v.s; tick = v.t; ml = v.l; mr = v.r; map = v.m;
        if (chk_en) sb_q.push_back(v);
        @(posedge clk);
        #1;
        start = 1'b0; tick = 1'b0; ml = '0; mr = '0; map = '0;
        if (chk_en) begin
            if (sb_q.size() == 0) begin
                chk({tag, ".sb_empty"}, 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                compare(e, tag);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t       e;
        logic [15:0] exp_sc;
        logic       en;

        //            s  t  l      r      map    pos    lives  score     st al     hf     cw wpos
        vecs[0]  = mk(1, 0, 2'b00, 2'b00, 8'h00, 8'h11, 6'h1B, 16'h0000, 1, 2'b11, 2'b00, 1, 8'h11);
        vecs[1]  = mk(0, 0, 2'b10, 2'b00, 8'h00, 8'h21, 6'h1B, 16'h0000, 1, 2'b11, 2'b00, 1, 8'h21);
        vecs[2]  = mk(0, 0, 2'b10, 2'b00, 8'h00, 8'h41, 6'h1B, 16'h0000, 1, 2'b11, 2'b00, 1, 8'h41);
        vecs[3]  = mk(0, 0, 2'b10, 2'b00, 8'h00, 8'h81, 6'h1B, 16'h0000, 1, 2'b11, 2'b00, 1, 8'h81);
        vecs[4]  = mk(0, 0, 2'b10, 2'b00, 8'h00, 8'h81, 6'h1B, 16'h0000, 1, 2'b11, 2'b00, 1, 8'h11);
        vecs[5]  = mk(0, 0, 2'b00, 2'b01, 8'h00, 8'h81, 6'h1B, 16'h0000, 1, 2'b11, 2'b00, 1, 8'h18);
        vecs[6]  = mk(0, 0, 2'b11, 2'b11, 8'h00, 8'h81, 6'h1B, 16'h0000, 1, 2'b11, 2'b00, 1, 8'h18);
        vecs[7]  = mk(0, 1, 2'b00, 2'b00, 8'h00, 8'h81, 6'h1B, 16'h0101, 1, 2'b11, 2'b00, 1, 8'h18);
        vecs[8]  = mk(0, 1, 2'b00, 2'b00, 8'h01, 8'h81, 6'h1A, 16'h0202, 1, 2'b11, 2'b01, 1, 8'h18);
        vecs[9]  = mk(0, 1, 2'b00, 2'b00, 8'h01, 8'h81, 6'h1A, 16'h0303, 1, 2'b11, 2'b01, 1, 8'h18);
        vecs[10] = mk(0, 1, 2'b00, 2'b00, 8'h01, 8'h81, 6'h1A, 16'h0404, 1, 2'b11, 2'b00, 1, 8'h18);
        vecs[11] = mk(0, 1, 2'b01, 2'b00, 8'h01, 8'h82, 6'h19, 16'h0505, 1, 2'b11, 2'b01, 1, 8'h11);
        vecs[12] = mk(0, 0, 2'b00, 2'b00, 8'h00, 8'h82, 6'h19, 16'h0505, 1, 2'b11, 2'b01, 0, 8'h00);
        vecs[13] = mk(0, 1, 2'b00, 2'b00, 8'h80, 8'h82, 6'h11, 16'h0606, 1, 2'b11, 2'b11, 0, 8'h00);
        vecs[14] = mk(0, 1, 2'b00, 2'b00, 8'h00, 8'h82, 6'h11, 16'h0707, 1, 2'b11, 2'b10, 0, 8'h00);
        vecs[15] = mk(0, 1, 2'b00, 2'b00, 8'h00, 8'h82, 6'h11, 16'h0808, 1, 2'b11, 2'b00, 0, 8'h00);
        vecs[16] = mk(0, 1, 2'b00, 2'b00, 8'h00, 8'h82, 6'h11, 16'h0909, 1, 2'b11, 2'b00, 0, 8'h00);
        vecs[17] = mk(0, 1, 2'b00, 2'b00, 8'h00, 8'h82, 6'h11, 16'h1010, 1, 2'b11, 2'b00, 0, 8'h00);
        vecs[18] = mk(0, 1, 2'b00, 2'b00, 8'h02, 8'h80, 6'h10, 16'h1110, 1, 2'b10, 2'b00, 0, 8'h00);
        vecs[19] = mk(0, 0, 2'b01, 2'b10, 8'h00, 8'h40, 6'h10, 16'h1110, 1, 2'b10, 2'b00, 0, 8'h00);
        vecs[20] = mk(0, 1, 2'b00, 2'b00, 8'h40, 8'h40, 6'h08, 16'h1210, 1, 2'b10, 2'b10, 0, 8'h00);
        vecs[21] = mk(0, 1, 2'b00, 2'b00, 8'h40, 8'h40, 6'h08, 16'h1310, 1, 2'b10, 2'b10, 0, 8'h00);
        vecs[22] = mk(0, 1, 2'b00, 2'b00, 8'h40, 8'h40, 6'h08, 16'h1410, 1, 2'b10, 2'b00, 0, 8'h00);
        vecs[23] = mk(0, 1, 2'b00, 2'b00, 8'h40, 8'h00, 6'h00, 16'h1410, 2, 2'b00, 2'b00, 0, 8'h00);
        vecs[24] = mk(0, 1, 2'b11, 2'b00, 8'hFF, 8'h00, 6'h00, 16'h1410, 2, 2'b00, 2'b00, 0, 8'h00);
        vecs[25] = mk(1, 0, 2'b00, 2'b00, 8'h00, 8'h11, 6'h1B, 16'h0000, 0, 2'b11, 2'b00, 0, 8'h00);
        vecs[26] = mk(1, 1, 2'b00, 2'b00, 8'h00, 8'h11, 6'h1B, 16'h0000, 1, 2'b11, 2'b00, 0, 8'h00);

        // Reset values while reset is held.
        repeat (3) @(posedge clk);
        #1;
        compare(mk(0, 0, 2'b00, 2'b00, 8'h00, 8'h11, 6'h1B, 16'h0000, 0, 2'b11, 2'b00, 1, 8'h11),
                "reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 27; i++) step(vecs[i], 1'b1, $sformatf("row%0d", i));

        // Clean ticks from score 0: BCD carry and saturation.
        for (int i = 1; i <= 105; i++) begin
            en     = (i == 9) || (i == 10) || (i == 105);
            exp_sc = (i == 9) ? 16'h0909 : (i == 10) ? 16'h1010 : 16'h9999;
            e = mk(0, 1, 2'b00, 2'b00, 8'h00, 8'h11, 6'h1B, exp_sc, 1, 2'b11, 2'b00, 0, 8'h00);
            step(e, en, $sformatf("sat_tick%0d", i));
        end

        // Reset mid-RUN with player 0 at bit 3 and score 0x12.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(1, 0, 2'b00, 2'b00, 8'h00, 8'h11, 6'h1B, 16'h0000, 1, 2'b11, 2'b00, 0, 8'h00),
             1'b1, "rerun");
        for (int i = 0; i < 12; i++)
            step(mk(0, 1, 2'b00, 2'b00, 8'h00, 8'h00, 6'h00, 16'h0000, 0, 2'b00, 2'b00, 0, 8'h00),
                 1'b0, "run12");
        for (int i = 0; i < 3; i++)
            step(mk(0, 0, 2'b01, 2'b00, 8'h00, 8'h18, 6'h1B, 16'h1212, 1, 2'b11, 2'b00, 0, 8'h00),
                 (i == 2), "pre_reset");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        compare(mk(0, 0, 2'b00, 2'b00, 8'h00, 8'h11, 6'h1B, 16'h0000, 0, 2'b11, 2'b00, 1, 8'h11),
                "async_reset");
        @(posedge clk);
        #1;
        compare(mk(0, 0, 2'b00, 2'b00, 8'h00, 8'h11, 6'h1B, 16'h0000, 0, 2'b11, 2'b00, 1, 8'h11),
                "reset_held");
        @(negedge clk);
        rst_n = 1'b1;
        step(mk(0, 1, 2'b01, 2'b00, 8'h01, 8'h11, 6'h1B, 16'h0000, 0, 2'b11, 2'b00, 1, 8'h11),
             1'b1, "idle_after_reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
